// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared timer for up to NREQ requester FSMs.
// Optional RUN watchdog is compiled in when TIMER_ARB_WDOG_EN is defined.
module timer_arbiter #(
  parameter int NREQ     = 3,
  parameter int SEL_W    = 4,
  parameter int WDOG_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SEL_W-1:0] req_sel,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [SEL_W-1:0]      tmr_sel,
  output logic                  tmr_ld,
  input  logic [SEL_W-1:0]      tmr_T
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || WDOG_CYC < 1) begin : g_param_chk
    $error("timer_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, own, own_n, win_idx;
  logic             win_found;
  logic [SEL_W-1:0] cur_sel, cur_sel_n, win_sel;
  logic [SEL_W-1:0] sel_arr [NREQ];

  logic [NREQ-1:0]  gnt_n, done_n;
  logic             err_n, busy_n, tmr_ld_n;
  logic [SEL_W-1:0] tmr_sel_n;

`ifdef TIMER_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYC + 1);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(WDOG_CYC - 1);
  logic [CNT_W-1:0] wdog_cnt, wdog_cnt_n;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic is_onehot(input logic [SEL_W-1:0] s);
    return (s != '0) && ((s & (s - 1'b1)) == '0);
  endfunction

  function automatic logic [NREQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_sel
    assign sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
  end

  // Round-robin scan: first asserted request at or after ptr, wrapping.
  always_comb begin
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = ptr_inc(cand);
    end
  end

  assign win_sel = sel_arr[win_idx];

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    own_n     = own;
    cur_sel_n = cur_sel;
    gnt_n     = '0;
    done_n    = '0;
    err_n     = 1'b0;
    busy_n    = 1'b0;
    tmr_sel_n = '0;
    tmr_ld_n  = 1'b0;
`ifdef TIMER_ARB_WDOG_EN
    wdog_cnt_n = wdog_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (win_found) begin
          if (!is_onehot(win_sel)) begin
            err_n = 1'b1;
            ptr_n = ptr_inc(win_idx);
          end else begin
            own_n     = win_idx;
            cur_sel_n = win_sel;
            state_n   = LOAD;
            gnt_n     = to_onehot(win_idx);
            busy_n    = 1'b1;
            tmr_sel_n = win_sel;
            tmr_ld_n  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_n   = RUN;
        gnt_n     = to_onehot(own);
        busy_n    = 1'b1;
        tmr_sel_n = cur_sel;
`ifdef TIMER_ARB_WDOG_EN
        wdog_cnt_n = '0;
`endif
      end
      RUN: begin
        // Abort outranks expiry; expiry outranks the watchdog.
        if (!req[own]) begin
          state_n = IDLE;
          ptr_n   = ptr_inc(own);
        end else if ((tmr_T & cur_sel) != '0) begin
          state_n = DONE;
          done_n  = to_onehot(own);
        end
`ifdef TIMER_ARB_WDOG_EN
        else if (wdog_cnt == WD_MAX) begin
          state_n = DONE;
          done_n  = to_onehot(own);
          err_n   = 1'b1;
        end
`endif
        else begin
          gnt_n     = to_onehot(own);
          busy_n    = 1'b1;
          tmr_sel_n = cur_sel;
`ifdef TIMER_ARB_WDOG_EN
          wdog_cnt_n = wdog_cnt + 1'b1;
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = ptr_inc(own);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      cur_sel <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      tmr_sel <= '0;
      tmr_ld  <= 1'b0;
`ifdef TIMER_ARB_WDOG_EN
      wdog_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      own     <= own_n;
      cur_sel <= cur_sel_n;
      gnt     <= gnt_n;
      done    <= done_n;
      err     <= err_n;
      busy    <= busy_n;
      tmr_sel <= tmr_sel_n;
      tmr_ld  <= tmr_ld_n;
`ifdef TIMER_ARB_WDOG_EN
      wdog_cnt <= wdog_cnt_n;
`endif
    end
  end

endmodule
